// File: rtl/ifetch_pc_unit_pkg.sv
// Shared fetch-side constants: FSM encoding, reset PC default, npc result type.
package ifetch_pc_unit_pkg;

    localparam int PC_W = 32;

    // FSM encoding (legacy-compatible constants)
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_TRAP = 2'd3;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int              IMEM_WORDS_DEFAULT = 128;

    // Result of next-pc selection for one cycle
    typedef struct packed {
        logic [PC_W-1:0] npc;          // candidate next pc
        logic            load;         // candidate is legal and should be loaded
        logic            misalign;     // candidate attempted but bits [1:0] != 0
        logic            out_of_range; // candidate attempted but >= imem byte size
    } npc_res_t;

    // One-past-last legal byte address, kept 33 bits wide so 32-bit wrap compares correctly
    function automatic logic [PC_W:0] imem_limit(input int words);
        return 33'(words) << 2;
    endfunction

endpackage

// File: rtl/ifetch_pc_unit_if.sv
// Control/redirect inputs and fetch-status outputs of the pc unit.
interface ifetch_pc_unit_if;

    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        resume;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        trap_misalign;
    logic        trap_range;
    logic [1:0]  state;
    logic [31:0] fetch_count;

    // Pipeline control side
    modport master (
        output stall, br_taken, br_target, jump, jump_target, halt_req, resume,
        input  pc, pc_plus4, fetch_valid, trap_misalign, trap_range, state, fetch_count
    );

    // pc unit side
    modport slave (
        input  stall, br_taken, br_target, jump, jump_target, halt_req, resume,
        output pc, pc_plus4, fetch_valid, trap_misalign, trap_range, state, fetch_count
    );

endinterface

// File: rtl/npc_select.sv
// Combinational next-pc priority mux plus alignment/range legality check.
module npc_select
    import ifetch_pc_unit_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic [31:0] pc_i,
    input  logic        halt_req_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_plus4_o,
    output npc_res_t    res_o
);

    localparam logic [32:0] LIMIT = imem_limit(IMEM_WORDS);

    logic [32:0] seq_sum;
    logic [32:0] cand;
    logic        advance;
    logic        mis;
    logic        oor;

    // Carry bit kept so a wrap of pc+4 shows up as out of range
    assign seq_sum    = {1'b0, pc_i} + 33'd4;
    assign pc_plus4_o = seq_sum[31:0];

    // Candidate selection: jump beats branch beats sequential
    always_comb begin
        cand = seq_sum;
        if (jump_i)
            cand = {1'b0, jump_target_i};
        else if (br_taken_i)
            cand = {1'b0, br_target_i};
    end

    // halt_req and stall both suppress any advance
    assign advance = !halt_req_i && !stall_i;
    assign mis     = advance && (cand[1:0] != 2'b00);
    assign oor     = advance && (cand >= LIMIT);

    // Pack result for the FSM
    always_comb begin
        res_o              = '0;
        res_o.npc          = cand[31:0];
        res_o.misalign     = mis;
        res_o.out_of_range = oor;
        res_o.load         = advance && !mis && !oor;
    end

endmodule

// File: rtl/ifetch_pc_unit.sv
// Fetch pc unit: BOOT/RUN/HALT/TRAP FSM, pc register, sticky traps, fetch counter.
module ifetch_pc_unit
    import ifetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    ifetch_pc_unit_if.slave   bus
);

    // A misconfigured reset pc would trap or fetch garbage on the first cycle
    if ((RESET_PC[1:0] != 2'b00) || ({1'b0, RESET_PC} >= imem_limit(IMEM_WORDS))) begin : g_bad_reset_pc
        $error("ifetch_pc_unit: RESET_PC must be word-aligned and inside instruction memory");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        oor_q, oor_d;
    npc_res_t    res;
    logic [31:0] pc_plus4;

    npc_select #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_npc_select (
        .pc_i          (pc_q),
        .halt_req_i    (bus.halt_req),
        .stall_i       (bus.stall),
        .jump_i        (bus.jump),
        .jump_target_i (bus.jump_target),
        .br_taken_i    (bus.br_taken),
        .br_target_i   (bus.br_target),
        .pc_plus4_o    (pc_plus4),
        .res_o         (res)
    );

    // Next-state: FSM transitions, pc load, trap capture and saturating count
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        oor_d   = oor_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (res.misalign || res.out_of_range) begin
                    state_d = ST_TRAP;
                    mis_d   = mis_q | res.misalign;
                    oor_d   = oor_q | res.out_of_range;
                end else if (res.load) begin
                    pc_d = res.npc;
                    if (cnt_q != 32'hFFFF_FFFF)
                        cnt_d = cnt_q + 32'd1;
                end
            end
            ST_HALT: begin
                // halt_req wins over a simultaneous resume
                if (!bus.halt_req && bus.resume)
                    state_d = ST_RUN;
            end
            default: ;  // TRAP absorbs until reset
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            oor_q   <= oor_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.fetch_valid   = (state_q == ST_RUN) && !bus.stall;
    assign bus.trap_misalign = mis_q;
    assign bus.trap_range    = oor_q;
    assign bus.state         = state_q;
    assign bus.fetch_count   = cnt_q;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed bench for ifetch_pc_unit with hand-computed expectations.
module tb_ifetch_pc_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ifetch_pc_unit_if bus ();

    ifetch_pc_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall       = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0;
        bus.jump        = 1'b0;
        bus.jump_target = 32'h0;
        bus.halt_req    = 1'b0;
        bus.resume      = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_pc"}, bus.pc, 32'h0);
        chk({tag, "_cnt"}, bus.fetch_count, 32'd0);
        chk({tag, "_mis"}, 32'(bus.trap_misalign), 32'd0);
        chk({tag, "_rng"}, 32'(bus.trap_range), 32'd0);
        chk({tag, "_fv"}, 32'(bus.fetch_valid), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk_reset_state("reset");

        // Free run: BOOT pc 0, then 0,4,8,12,16
        rst = 1'b0;
        #1;
        chk("boot_fv", 32'(bus.fetch_valid), 32'd0);
        tick();
        chk("run_state", 32'(bus.state), 32'd1);
        chk("run_pc0", bus.pc, 32'h0);
        chk("run_fv", 32'(bus.fetch_valid), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", bus.pc, 32'(4 * i));
        end
        chk("seq_cnt", bus.fetch_count, 32'd4);
        chk("pc_plus4", bus.pc_plus4, 32'h14);

        // jump beats branch at pc 0x10
        bus.jump = 1'b1; bus.jump_target = 32'h40;
        bus.br_taken = 1'b1; bus.br_target = 32'h80;
        tick();
        chk("jmp_prio_pc", bus.pc, 32'h40);
        chk("jmp_prio_cnt", bus.fetch_count, 32'd5);

        // Go to 0x20, then stall 3 cycles
        clear_inputs();
        bus.jump = 1'b1; bus.jump_target = 32'h20;
        tick();
        chk("to20_pc", bus.pc, 32'h20);
        clear_inputs();
        bus.stall = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 32'h100;  // stall outranks jump
        #1;
        chk("stall_fv", 32'(bus.fetch_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.pc, 32'h20);
        end
        chk("stall_cnt", bus.fetch_count, 32'd6);
        clear_inputs();
        tick();
        chk("unstall_pc", bus.pc, 32'h24);
        chk("unstall_cnt", bus.fetch_count, 32'd7);

        // Halt at 0x08
        bus.jump = 1'b1; bus.jump_target = 32'h08;
        tick();
        clear_inputs();
        bus.halt_req = 1'b1;
        #1;
        chk("halt_req_fv", 32'(bus.fetch_valid), 32'd1);
        tick();
        chk("halt_state", 32'(bus.state), 32'd2);
        chk("halt_pc", bus.pc, 32'h08);
        chk("halt_fv", 32'(bus.fetch_valid), 32'd0);
        bus.halt_req = 1'b0;
        tick();
        chk("halt_hold_state", 32'(bus.state), 32'd2);
        bus.resume = 1'b1;
        tick();
        chk("resume_state", 32'(bus.state), 32'd1);
        chk("resume_pc", bus.pc, 32'h08);
        bus.resume = 1'b0;
        tick();
        chk("resume_next_pc", bus.pc, 32'h0C);
        chk("resume_cnt", bus.fetch_count, 32'd9);
        bus.halt_req = 1'b1; bus.stall = 1'b1;
        tick();
        chk("halt2_state", 32'(bus.state), 32'd2);
        bus.stall = 1'b0; bus.resume = 1'b1;
        tick();
        chk("halt_resume_prio", 32'(bus.state), 32'd2);
        chk("halt_resume_pc", bus.pc, 32'h0C);

        // Reset mid-HALT
        clear_inputs();
        rst = 1'b1;
        tick();
        chk_reset_state("rst_halt");
        rst = 1'b0;
        tick();

        // Sequential overrun past last word
        bus.jump = 1'b1; bus.jump_target = 32'h1F8;
        tick();
        clear_inputs();
        tick();
        chk("last_pc", bus.pc, 32'h1FC);
        tick();
        chk("rng_flag", 32'(bus.trap_range), 32'd1);
        chk("rng_mis", 32'(bus.trap_misalign), 32'd0);
        chk("rng_state", 32'(bus.state), 32'd3);
        chk("rng_pc", bus.pc, 32'h1FC);
        chk("rng_cnt", bus.fetch_count, 32'd2);
        chk("trap_fv", 32'(bus.fetch_valid), 32'd0);

        rst = 1'b1;
        tick();
        chk_reset_state("rst_trap");
        rst = 1'b0;
        tick();

        // Misaligned branch, then resume is ignored
        bus.br_taken = 1'b1; bus.br_target = 32'h42;
        tick();
        chk("mis_flag", 32'(bus.trap_misalign), 32'd1);
        chk("mis_rng", 32'(bus.trap_range), 32'd0);
        chk("mis_state", 32'(bus.state), 32'd3);
        chk("mis_pc", bus.pc, 32'h0);
        clear_inputs();
        bus.resume = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 32'h10;
        tick();
        chk("trap_resume_state", 32'(bus.state), 32'd3);
        chk("trap_resume_pc", bus.pc, 32'h0);
        clear_inputs();
        rst = 1'b1;
        tick();
        chk_reset_state("rst_mis");
        rst = 1'b0;
        tick();

        // Jump to exactly the first illegal byte: range only
        bus.jump = 1'b1; bus.jump_target = 32'h200;
        tick();
        chk("edge_rng", 32'(bus.trap_range), 32'd1);
        chk("edge_mis", 32'(bus.trap_misalign), 32'd0);
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Misaligned and out of range together
        bus.jump = 1'b1; bus.jump_target = 32'h203;
        tick();
        chk("both_rng", 32'(bus.trap_range), 32'd1);
        chk("both_mis", 32'(bus.trap_misalign), 32'd1);
        chk("both_pc", bus.pc, 32'h0);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
